ram_sp_arb2: RTL

//  Two-requester arbiter/sequencer in front of one single-port synchronous RAM.
//  - Grants at most one access (read or write) per cycle.
//  - Arbitration is round-robin with bounded bursts: an owner keeps the port while it

---
 rtl/ram_sp_arb2.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ram_sp_arb2.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_arb2
// Brief    : Two-requester round-robin arbiter with bounded bursts in front of
//            one single-port synchronous RAM. One access per cycle, read data
//            returned one cycle after acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sp_arb2 #(
    parameter  int DATA_W    = 32,
    parameter  int DEPTH     = 256,
    parameter  int MAX_BURST = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [1:0]             req_we_i,
    input  logic [1:0][AW-1:0]     req_addr_i,
    input  logic [1:0][DATA_W-1:0] req_wdata_i,
    output logic [1:0]             rsp_valid_o,
    output logic [DATA_W-1:0]      rsp_rdata_o,
    output logic                   ram_wen_o,
    output logic [AW-1:0]          ram_addr_o,
    output logic [DATA_W-1:0]      ram_wdata_o,
    input  logic [DATA_W-1:0]      ram_rdata_i
);

    // Counter wide enough to hold MAX_BURST itself (it saturates there).
    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rr_ptr;
    logic             rr_nxt;
    logic [1:0]       grant;
    logic             owner;
    logic             other;
    logic             gidx;

    // Current owner index while in an OWN state.
    assign owner = (state == OWN1);
    assign other = ~owner;

    // State, beat counter and tie-break pointer registers.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            cnt    <= CNT_ZERO;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Arbitration: next state and same-cycle grant.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rr_nxt    = rr_ptr;
        grant     = 2'b00;
        case (state)
            IDLE: begin
                if (req_valid_i == 2'b11) begin
                    grant[rr_ptr] = 1'b1;
                    state_nxt     = rr_ptr ? OWN1 : OWN0;
                    cnt_nxt       = CNT_ONE;
                    rr_nxt        = ~rr_ptr;
                end else if (req_valid_i[0]) begin
                    grant[0]  = 1'b1;
                    state_nxt = OWN0;
                    cnt_nxt   = CNT_ONE;
                end else if (req_valid_i[1]) begin
                    grant[1]  = 1'b1;
                    state_nxt = OWN1;
                    cnt_nxt   = CNT_ONE;
                end
            end
            OWN0, OWN1: begin
                if (req_valid_i[owner] && (!req_valid_i[other] || (cnt < CNT_MAX))) begin
                    // Owner keeps streaming; counter saturates.
                    grant[owner] = 1'b1;
                    if (cnt < CNT_MAX) begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else if (req_valid_i[other]) begin
                    // Burst limit reached or owner went quiet: hand over without a bubble.
                    grant[other] = 1'b1;
                    state_nxt    = other ? OWN1 : OWN0;
                    cnt_nxt      = CNT_ONE;
                    rr_nxt       = owner;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = CNT_ZERO;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    assign req_ready_o = rst_ni ? grant : 2'b00;
    assign gidx        = req_ready_o[1];
    assign ram_addr_o  = req_addr_i[gidx];
    assign ram_wdata_o = req_wdata_i[gidx];
    assign ram_wen_o   = |(req_ready_o & req_we_i);
    assign rsp_rdata_o = ram_rdata_i;

    // Read response flag, aligned with the RAM's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 2'b00;
        end else begin
            rsp_valid_o <= req_ready_o & ~req_we_i;
        end
    end

endmodule
`default_nettype wire
